// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit with run-time add/sub, signed/unsigned and wrap/saturate modes.
// Optional input register stage, registered output stage, valid/ready on both sides.
module addsub_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          REG_IN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             op,
  input  logic             sgn,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned MSB = WIDTH - 1;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             flag_z_q;
  logic             flag_n_q;
  logic             flag_c_q;
  logic             flag_v_q;

  // Output stage may load when empty or when its current result leaves this cycle.
  logic out_take;
  assign out_take = !out_valid_q || out_ready;

  logic             ex_valid;
  logic [WIDTH-1:0] ex_x;
  logic [WIDTH-1:0] ex_y;
  logic             ex_op;
  logic             ex_sgn;
  logic             ex_sat;

  generate
    if (REG_IN) begin : g_in_reg
      logic             s1_valid_q;
      logic [WIDTH-1:0] s1_x_q;
      logic [WIDTH-1:0] s1_y_q;
      logic             s1_op_q;
      logic             s1_sgn_q;
      logic             s1_sat_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid_q <= 1'b0;
          s1_x_q     <= '0;
          s1_y_q     <= '0;
          s1_op_q    <= 1'b0;
          s1_sgn_q   <= 1'b0;
          s1_sat_q   <= 1'b0;
        end else if (in_ready) begin
          s1_valid_q <= in_valid;
          if (in_valid) begin
            s1_x_q   <= X;
            s1_y_q   <= Y;
            s1_op_q  <= op;
            s1_sgn_q <= sgn;
            s1_sat_q <= sat;
          end
        end
      end

      assign in_ready = !s1_valid_q || out_take;
      assign ex_valid = s1_valid_q;
      assign ex_x     = s1_x_q;
      assign ex_y     = s1_y_q;
      assign ex_op    = s1_op_q;
      assign ex_sgn   = s1_sgn_q;
      assign ex_sat   = s1_sat_q;
    end else begin : g_in_bypass
      assign in_ready = out_take;
      assign ex_valid = in_valid;
      assign ex_x     = X;
      assign ex_y     = Y;
      assign ex_op    = op;
      assign ex_sgn   = sgn;
      assign ex_sat   = sat;
    end
  endgenerate

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] result_d;
  logic             flag_c_d;
  logic             flag_v_d;

  // Carry/overflow describe the unsaturated operation; saturation only replaces the value.
  always_comb begin
    if (ex_op) begin
      sum_ext = {1'b0, ex_x} + {1'b0, ex_y};
    end else begin
      sum_ext = {1'b0, ex_x} + {1'b0, ~ex_y} + {{WIDTH{1'b0}}, 1'b1};
    end
    raw = sum_ext[WIDTH-1:0];

    if (ex_op) begin
      flag_c_d = sum_ext[WIDTH];
      flag_v_d = (ex_x[MSB] == ex_y[MSB]) && (raw[MSB] != ex_x[MSB]);
    end else begin
      flag_c_d = (ex_x < ex_y);
      flag_v_d = (ex_x[MSB] != ex_y[MSB]) && (raw[MSB] != ex_x[MSB]);
    end

    result_d = raw;
    if (ex_sat) begin
      if (!ex_sgn) begin
        if (flag_c_d) begin
          result_d = ex_op ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end
      end else if (flag_v_d) begin
        result_d = ex_x[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
    end else if (out_take) begin
      out_valid_q <= ex_valid;
      if (ex_valid) begin
        result_q <= result_d;
        flag_z_q <= (result_d == '0);
        flag_n_q <= result_d[MSB];
        flag_c_q <= flag_c_d;
        flag_v_q <= flag_v_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: table vectors, backpressure, reset and random stream checked
// through a scoreboard queue; a second instance with the input stage bypassed.
module tb_addsub_pipe;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         op;
    logic         sgn;
    logic         sat;
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] X = '0;
  logic [W-1:0] Y = '0;
  logic         op = 1'b0;
  logic         sgn = 1'b0;
  logic         sat = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         fz, fn, fc, fv;

  logic         in_valid0 = 1'b0;
  logic         in_ready0;
  logic         out_valid0;
  logic         out_ready0 = 1'b1;
  logic [W-1:0] result0;
  logic         fz0, fn0, fc0, fv0;

  int errors = 0;
  int checks = 0;
  int out_cnt = 0;
  vec_t sb[$];

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(W), .REG_IN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .op(op), .sgn(sgn), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_z(fz), .flag_n(fn), .flag_c(fc), .flag_v(fv)
  );

  addsub_pipe #(.WIDTH(W), .REG_IN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .X(X), .Y(Y), .op(op), .sgn(sgn), .sat(sat),
    .out_valid(out_valid0), .out_ready(out_ready0), .result(result0),
    .flag_z(fz0), .flag_n(fn0), .flag_c(fc0), .flag_v(fv0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Integer reference model, independent of the bit-level formulation.
  function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic o, input logic s, input logic st);
    vec_t r;
    int ux, uy, sx, sy, ur, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ur = o ? ux + uy : ux - uy;
    sr = o ? sx + sy : sx - sy;
    r.x = x; r.y = y; r.op = o; r.sgn = s; r.sat = st;
    r.c = o ? (ur > 255) : (ux < uy);
    r.v = (sr > 127) || (sr < -128);
    r.res = W'(ur);
    if (st) begin
      if (!s && r.c) r.res = o ? 8'hFF : 8'h00;
      else if (s && r.v) r.res = (sr > 0) ? 8'h7F : 8'h80;
    end
    r.z = (r.res == 8'h00);
    r.n = r.res[W-1];
    return r;
  endfunction

  task automatic apply(input vec_t v);
    X = v.x; Y = v.y; op = v.op; sgn = v.sgn; sat = v.sat;
  endtask

  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    apply(v);
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(v);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  // Output monitor: scoreboard compare on each transfer, stability check while stalled.
  logic        stall_prev = 1'b0;
  logic [11:0] stall_val = '0;
  always @(negedge clk) begin
    vec_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", {20'd0, result, fz, fn, fc, fv}, {20'd0, stall_val});
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result 0x%0h with no pending expectation", result);
        end else begin
          e = sb.pop_front();
          chk("out_data", {20'd0, result, fz, fn, fc, fv},
              {20'd0, e.res, e.z, e.n, e.c, e.v});
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_val  = {result, fz, fn, fc, fv};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    vec_t bp[4];
    vec_t rv;
    int   lat, idx, c0;
    bit   acc, done;
    logic [W-1:0] held;

    //        x      y      op    sgn   sat   res    z     n     c     v
    tbl[0] = '{8'd10, 8'd5,   1'b0, 1'b0, 1'b0, 8'd5,   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'd5,  8'd10,  1'b0, 1'b0, 1'b0, 8'd251, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'd5,  8'd10,  1'b0, 1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'd100,8'd100, 1'b1, 1'b1, 1'b0, 8'd200, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'd100,8'd100, 1'b1, 1'b1, 1'b1, 8'd127, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h80, 8'd1,   1'b0, 1'b1, 1'b1, 8'h80,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{8'd200,8'd100, 1'b1, 1'b0, 1'b1, 8'd255, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{8'd0,  8'd0,   1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{8'd255,8'd1,   1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{8'h7F, 8'hFF,  1'b0, 1'b1, 1'b1, 8'h7F,  1'b0, 1'b0, 1'b1, 1'b1};

    bp[0] = model(8'd1,   8'd2,   1'b1, 1'b0, 1'b0);
    bp[1] = model(8'd200, 8'd100, 1'b1, 1'b0, 1'b1);
    bp[2] = model(8'd3,   8'd9,   1'b0, 1'b1, 1'b0);
    bp[3] = model(8'd127, 8'd1,   1'b1, 1'b1, 1'b1);

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {28'd0, fz, fn, fc, fv}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_in_ready0", 32'(in_ready0), 32'd1);

    // Latency with input register stage
    apply(tbl[0]);
    in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    if (in_ready) sb.push_back(tbl[0]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency_reg_in1", lat, 2);
    drain();

    // Table vectors, back-to-back
    for (int i = 0; i < 10; i++) send(tbl[i]);
    drain();

    // Backpressure: four inputs offered while the output is blocked
    @(posedge clk); #1;
    out_ready = 1'b0;
    idx = 0;
    apply(bp[0]);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back(bp[idx]);
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        apply(bp[idx]);
      end
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    held = result;
    repeat (3) @(negedge clk);
    chk("bp_held_result", 32'(result), 32'(held));
    chk("bp_held_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    c0 = out_cnt;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sb.push_back(bp[idx]);
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) apply(bp[idx]);
        else in_valid = 1'b0;
      end
    end
    chk("bp_one_per_cycle", out_cnt - c0, 4);
    in_valid = 1'b0;
    drain();

    // Reset with two transactions in flight
    out_ready = 1'b0;
    send(tbl[3]);
    send(tbl[5]);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_flags", {28'd0, fz, fn, fc, fv}, 32'd0);
    sb.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    c0 = out_cnt;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("postrst_no_output", out_cnt - c0, 0);
    send(tbl[1]);
    drain();
    chk("postrst_one_output", out_cnt - c0, 1);

    // Random stream under random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          rv = model(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
          send(rv);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Bypassed input stage: latency 1 and the same arithmetic
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i]);
      in_valid0 = 1'b1;
      @(negedge clk);
      chk("byp_in_ready", 32'(in_ready0), 32'd1);
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      lat = 1;
      while (!out_valid0 && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("latency_reg_in0", lat, 1);
      chk("byp_data", {20'd0, result0, fz0, fn0, fc0, fv0},
          {20'd0, tbl[i].res, tbl[i].z, tbl[i].n, tbl[i].c, tbl[i].v});
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
